sysid_checker: RTL

- Avalon-MM read master that queries the system-ID slave over the fabric at boot or on demand.
- Issues two reads: offset 0 returns the system ID, offset 4 returns the build timestamp.
- Compares both words against compile-time expected values and latches the results.
- Exposes pass/fail/timeout status to reset/boot logic or the LED/debug block, so a mismatched software image and FPGA build are detected without a CPU.

---
 rtl/sysid_pkg.sv | 22 ++
 rtl/sysid_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared types and constants for the sysid checker
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID_REQ,
    ST_RD_ID_WAIT,
    ST_RD_TS_REQ,
    ST_RD_TS_WAIT,
    ST_FIN
  } sysid_state_e;

  localparam int SYSID_ID_OFS = 0;
  localparam int SYSID_TS_OFS = 4;

  // Must track the values baked into the sysid slave generator
  localparam logic [31:0] SYSID_DEF_ID = 32'd1520569647;
  localparam logic [31:0] SYSID_DEF_TS = 32'd1195523523;

  localparam int MAX_RETRIES = 3;

endpackage

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - Avalon-MM reader that verifies system ID and build timestamp
// Optional SYSID_CHECKER_RETRY_EN: rerun failed checks up to MAX_RETRIES times, adds retry_cnt.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       EXPECTED_ID    = SYSID_DEF_ID,
  parameter logic [31:0]       EXPECTED_TS    = SYSID_DEF_TS,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter bit                AUTO_START     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
`ifdef SYSID_CHECKER_RETRY_EN
  ,
  output logic [1:0]        retry_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ID = BASE_ADDR + ADDR_W'(SYSID_ID_OFS);
  localparam logic [ADDR_W-1:0] ADDR_TS = BASE_ADDR + ADDR_W'(SYSID_TS_OFS);
  // Budget covers REQ plus WAIT; expiry fires on the edge that would make the count reach TIMEOUT_CYCLES
  localparam logic [15:0]       TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  sysid_state_e      r_state;
  logic              r_auto_pend;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_address;
  logic              r_read;
  logic              r_busy;
  logic              r_done;
  logic              r_id_ok;
  logic              r_ts_ok;
  logic              r_timeout;
  logic [31:0]       r_id_value;
  logic [31:0]       r_ts_value;
`ifdef SYSID_CHECKER_RETRY_EN
  logic [1:0]        r_retry_cnt;
  logic              w_failed;
`endif
  logic              w_expire;

  assign w_expire = (r_cnt == TO_LAST);
`ifdef SYSID_CHECKER_RETRY_EN
  assign w_failed = !r_id_ok || !r_ts_ok || r_timeout;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_auto_pend <= AUTO_START;
      r_cnt       <= '0;
      r_address   <= BASE_ADDR;
      r_read      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_id_ok     <= 1'b0;
      r_ts_ok     <= 1'b0;
      r_timeout   <= 1'b0;
      r_id_value  <= '0;
      r_ts_value  <= '0;
`ifdef SYSID_CHECKER_RETRY_EN
      r_retry_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start || r_auto_pend) begin
            r_auto_pend <= 1'b0;
            r_state     <= ST_RD_ID_REQ;
            r_address   <= ADDR_ID;
            r_read      <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_id_ok     <= 1'b0;
            r_ts_ok     <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
            r_retry_cnt <= '0;
`endif
          end
        end
        ST_RD_ID_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_expire) begin
            r_timeout <= 1'b1;
            r_read    <= 1'b0;
            r_state   <= ST_FIN;
          end else if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= ST_RD_ID_WAIT;
          end
        end
        ST_RD_ID_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (avm_readdatavalid) begin
            r_id_value <= avm_readdata;
            r_id_ok    <= (avm_readdata == EXPECTED_ID);
            r_state    <= ST_RD_TS_REQ;
            r_address  <= ADDR_TS;
            r_read     <= 1'b1;
            r_cnt      <= '0;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_state   <= ST_FIN;
          end
        end
        ST_RD_TS_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_expire) begin
            r_timeout <= 1'b1;
            r_read    <= 1'b0;
            r_state   <= ST_FIN;
          end else if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= ST_RD_TS_WAIT;
          end
        end
        ST_RD_TS_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (avm_readdatavalid) begin
            r_ts_value <= avm_readdata;
            r_ts_ok    <= (avm_readdata == EXPECTED_TS);
            r_state    <= ST_FIN;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_state   <= ST_FIN;
          end
        end
        ST_FIN: begin
`ifdef SYSID_CHECKER_RETRY_EN
          if (w_failed && (r_retry_cnt != 2'(MAX_RETRIES))) begin
            r_retry_cnt <= r_retry_cnt + 2'd1;
            r_state     <= ST_RD_ID_REQ;
            r_address   <= ADDR_ID;
            r_read      <= 1'b1;
            r_cnt       <= '0;
            r_id_ok     <= 1'b0;
            r_ts_ok     <= 1'b0;
            r_timeout   <= 1'b0;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
`else
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign avm_address = r_address;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
`ifdef SYSID_CHECKER_RETRY_EN
  assign retry_cnt   = r_retry_cnt;
`endif

endmodule
